// File: rtl/spi_master_ctrl.sv
// SPI master: shifts 10-bit commands out MSB first and captures 8-bit replies for read-data frames.
// Define SPI_MASTER_STATUS_EN to add the busy and frames_done status outputs.
module spi_master_ctrl #(
    parameter int FRAME_W    = 10,
    parameter int RD_W       = 8,
    parameter int TURNAROUND = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [RD_W-1:0]    rsp_data,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
`ifdef SPI_MASTER_STATUS_EN
    ,
    output logic               busy,
    output logic [15:0]        frames_done
`endif
);

    localparam int MAX_AB  = (FRAME_W > RD_W) ? FRAME_W : RD_W;
    localparam int MAX_CD  = (TURNAROUND > IDLE_GAP) ? TURNAROUND : IDLE_GAP;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Every phase counter is loaded with length-1 and the phase ends when it reaches zero.
    localparam cnt_t FRAME_LOAD = cnt_t'(FRAME_W - 1);
    localparam cnt_t RD_LOAD    = cnt_t'(RD_W - 1);
    localparam cnt_t TURN_LOAD  = cnt_t'(TURNAROUND - 1);
    localparam cnt_t GAP_LOAD   = cnt_t'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_READ,
        ST_GAP
    } state_t;

    state_t             state;
    cnt_t               cnt;
    logic               rd_frame;
    logic [FRAME_W-1:0] shift_reg;
    logic [RD_W-2:0]    rx_shift;
    logic               accept;
    logic               is_rd;

    assign accept = cmd_valid && cmd_ready;
    assign is_rd  = (cmd_data[FRAME_W-1 -: 2] == 2'b11);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_GAP;
            cnt       <= GAP_LOAD;
            rd_frame  <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SHIFT;
                        cnt       <= FRAME_LOAD;
                        rd_frame  <= is_rd;
                        SS_n      <= 1'b0;
                        MOSI      <= cmd_data[FRAME_W-1];
                        cmd_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        MOSI <= 1'b0;
                        if (rd_frame) begin
                            state <= ST_WAIT;
                            cnt   <= TURN_LOAD;
                        end else begin
                            state <= ST_GAP;
                            cnt   <= GAP_LOAD;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt - cnt_t'(1);
                        MOSI <= shift_reg[FRAME_W-1];
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_READ;
                        cnt   <= RD_LOAD;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                ST_READ: begin
                    if (cnt == '0) begin
                        rsp_data  <= {rx_shift, MISO};
                        rsp_valid <= 1'b1;
                        state     <= ST_GAP;
                        cnt       <= GAP_LOAD;
                        SS_n      <= 1'b1;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                default: begin
                    state     <= ST_GAP;
                    cnt       <= GAP_LOAD;
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: pure datapath shifters carry no reset; the FSM never exposes their contents before loading them.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= {cmd_data[FRAME_W-2:0], 1'b0};
        end else if (state == ST_SHIFT) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
        end
        if (state == ST_READ) begin
            rx_shift <= {rx_shift[RD_W-3:0], MISO};
        end
    end

`ifdef SPI_MASTER_STATUS_EN
    logic frame_end;

    // Only frames that reach GAP naturally count; a reset abort bypasses this path.
    assign frame_end = ((state == ST_SHIFT) && (cnt == '0) && !rd_frame) ||
                       ((state == ST_READ) && (cnt == '0));
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_done <= '0;
        end else if (frame_end) begin
            frames_done <= frames_done + 16'd1;
        end
    end
`endif

endmodule
